// File: rtl/wall_game_fsm.sv
// -----------------------------------------------------------------------------
// wall_game_fsm
//   Game sequencer that sits in front of the pixel compositor. It moves the
//   approaching wall one depth step closer every FRAMES_PER_STEP frames. While
//   the wall is inside the goal window, it marks every pixel where a player
//   overlaps the wall as a collision and counts those pixels per frame. At each
//   frame boundary it decides whether the wall was passed or the game is lost.
//
// Ports
//   clk_in            pixel clock
//   rst_in            synchronous, active-high reset
//   hcount_in [10:0]  pixel column
//   vcount_in [9:0]   pixel row
//   is_player         current pixel belongs to a player mask
//   is_wall           current pixel belongs to the wall mask
//   start_in          debounced start button (level, edge-detected here)
//   wall_depth [7:0]  current wall depth
//   is_collision      collision flag for the pixel presented one cycle earlier
//   game_state_out    0 GAME_OVER, 1 IDLE, 2 APPROACH, 3 CHECK, 4 PASSED
//   score [7:0]       walls passed, saturating at 255
//   frame_collisions  collision pixel count of the last completed frame
//
// Build option
//   WALL_SPEEDUP_EN   when defined, the step period shrinks by one frame for
//                     every 4 walls passed (minimum 1 frame). The new period
//                     is recomputed each time the step counter wraps.
// -----------------------------------------------------------------------------
module wall_game_fsm #(
    parameter int ACTIVE_H_PIXELS     = 1280,
    parameter int ACTIVE_LINES        = 720,
    parameter int MAX_WALL_DEPTH      = 75,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int FRAMES_PER_STEP     = 4,
    parameter int COLLISION_THRESHOLD = 2000,
    parameter int PASS_FRAMES         = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        is_player,
    input  logic        is_wall,
    input  logic        start_in,
    output logic [7:0]  wall_depth,
    output logic        is_collision,
    output logic [2:0]  game_state_out,
    output logic [7:0]  score,
    output logic [20:0] frame_collisions
);

    typedef enum logic [2:0] {
        S_OVER  = 3'd0,
        S_IDLE  = 3'd1,
        S_APPR  = 3'd2,
        S_CHECK = 3'd3,
        S_PASS  = 3'd4
    } state_t;

    localparam logic [7:0]  MAX_D     = 8'(MAX_WALL_DEPTH);
    localparam logic [7:0]  WIN_LO    = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
    localparam logic [7:0]  WIN_HI    = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
    localparam logic [10:0] H_ACT     = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]  V_ACT     = 10'(ACTIVE_LINES);
    localparam logic [20:0] THRESH    = 21'(COLLISION_THRESHOLD);
    localparam logic [7:0]  STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]  PASS_LAST = 8'(PASS_FRAMES - 1);

    state_t      state, state_d;
    logic [7:0]  depth_d, score_d;
    logic [7:0]  step_cnt, step_d;
    logic [7:0]  pass_cnt, pass_d;
    logic [20:0] coll_cnt;
    logic        prev_origin, start_prev;
    logic        dec_evt;
    logic [7:0]  step_last;

    // The frame boundary is the first cycle at (0,0). If hcount stalls at the
    // origin, this still produces only one pulse for the frame.
    logic at_origin, frame_start, start_rise, coll_px, step_wrap, coll_fail;
    logic [7:0] depth_dec;

    assign at_origin   = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign frame_start = at_origin && !prev_origin;
    assign start_rise  = start_in && !start_prev;
    assign coll_px     = (state == S_CHECK) && is_player && is_wall &&
                         (hcount_in < H_ACT) && (vcount_in < V_ACT);
    assign step_wrap   = (step_cnt >= step_last);
    assign depth_dec   = (wall_depth == 8'd0) ? 8'd0 : wall_depth - 8'd1;
    // Compare against the count being latched this boundary. A collision
    // pixel arriving on the same cycle is charged to the new frame.
    assign coll_fail   = (coll_cnt > THRESH);

    assign game_state_out = state;

`ifdef WALL_SPEEDUP_EN
    logic [7:0] speed_red;
    assign speed_red = {2'b00, score[7:2]};
    // step_last holds (period - 1), so the floor of a 1-frame period is 0.
    always_ff @(posedge clk_in) begin
        if (rst_in)       step_last <= STEP_LAST;
        else if (dec_evt) step_last <= (STEP_LAST > speed_red) ? STEP_LAST - speed_red : 8'd0;
    end
`else
    assign step_last = STEP_LAST;
`endif

    always_comb begin
        state_d = state;
        depth_d = wall_depth;
        score_d = score;
        step_d  = step_cnt;
        pass_d  = pass_cnt;
        dec_evt = 1'b0;
        case (state)
            S_IDLE: begin
                depth_d = MAX_D;
                if (start_rise) begin
                    state_d = S_APPR;
                    score_d = 8'd0;
                    step_d  = 8'd0;
                end
            end
            S_APPR: begin
                if (frame_start) begin
                    if (step_wrap) begin
                        step_d  = 8'd0;
                        depth_d = depth_dec;
                        dec_evt = 1'b1;
                        if (depth_dec >= WIN_LO && depth_dec <= WIN_HI) state_d = S_CHECK;
                    end else begin
                        step_d = step_cnt + 8'd1;
                    end
                end
            end
            S_CHECK: begin
                if (frame_start) begin
                    if (coll_fail) begin
                        // Losing takes priority, so the depth stays frozen.
                        state_d = S_OVER;
                    end else if (step_wrap) begin
                        step_d  = 8'd0;
                        depth_d = depth_dec;
                        dec_evt = 1'b1;
                        if (depth_dec < WIN_LO) begin
                            state_d = S_PASS;
                            score_d = (score == 8'hFF) ? score : score + 8'd1;
                        end
                    end else begin
                        step_d = step_cnt + 8'd1;
                    end
                end
            end
            S_PASS: begin
                if (frame_start) begin
                    if (pass_cnt >= PASS_LAST) begin
                        pass_d  = 8'd0;
                        state_d = S_APPR;
                        depth_d = MAX_D;
                        step_d  = 8'd0;
                    end else begin
                        pass_d = pass_cnt + 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    depth_d = MAX_D;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            wall_depth  <= MAX_D;
            score       <= 8'd0;
            step_cnt    <= 8'd0;
            pass_cnt    <= 8'd0;
            prev_origin <= 1'b0;
            start_prev  <= 1'b0;
        end else begin
            state       <= state_d;
            wall_depth  <= depth_d;
            score       <= score_d;
            step_cnt    <= step_d;
            pass_cnt    <= pass_d;
            prev_origin <= at_origin;
            start_prev  <= start_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            is_collision     <= 1'b0;
            coll_cnt         <= 21'd0;
            frame_collisions <= 21'd0;
        end else begin
            is_collision <= coll_px;
            if (frame_start) begin
                frame_collisions <= coll_cnt;
                coll_cnt         <= {20'd0, coll_px};
            end else if (coll_px && coll_cnt != {21{1'b1}}) begin
                coll_cnt <= coll_cnt + 21'd1;
            end
        end
    end

endmodule

// File: tb/tb_wall_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_wall_game_fsm
//   Directed bench for wall_game_fsm on a small 16x8 active raster, which is
//   swept as a 20x10 frame. A table of frame-level records drives most of one
//   game, and hand-written sequences cover the start-hold and mid-frame reset
//   cases.
// -----------------------------------------------------------------------------
module tb_wall_game_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        is_player, is_wall, start;
    logic [7:0]  wall_depth, score;
    logic        is_collision;
    logic [2:0]  game_state;
    logic [20:0] frame_collisions;

    int n_chk  = 0;
    int n_fail = 0;

    wall_game_fsm #(
        .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(8), .MAX_WALL_DEPTH(20),
        .GOAL_DEPTH(10), .GOAL_DEPTH_DELTA(2), .FRAMES_PER_STEP(2),
        .COLLISION_THRESHOLD(5), .PASS_FRAMES(3)
    ) dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .is_player(is_player), .is_wall(is_wall), .start_in(start),
        .wall_depth(wall_depth), .is_collision(is_collision),
        .game_state_out(game_state), .score(score),
        .frame_collisions(frame_collisions)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;    // pulse start_in before the frames
        int          frames;   // full frames to sweep
        int          ovl_in;   // overlap pixels inside the active area (row 1)
        int          ovl_out;  // overlap pixels outside the active area
        logic        coll_en;  // state is CHECK during these frames
        logic [2:0]  st;
        logic [7:0]  depth;
        logic [7:0]  sc;
        logic [20:0] fc;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pix(input int h, input int v, input logic p, input logic w);
        hcount    = 11'(h);
        vcount    = 10'(v);
        is_player = p;
        is_wall   = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic s);
        start = s;
        pix(19, 9, 1'b0, 1'b0);
    endtask

    // Sweeps one full frame. It also drives player-only pixels (row 2) and
    // wall-only pixels (row 3), neither of which may register as a collision.
    task automatic run_frame(input int ovl_in, input int ovl_out, input logic coll_en);
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 20; h++) begin
                logic hit_in, hit_out, p, w;
                hit_in  = (v == 1) && (h < ovl_in);
                hit_out = ((v == 1) && (h >= 16) && (h < 16 + ovl_out)) ||
                          ((v == 8) && (h < ovl_out));
                p = hit_in || hit_out || ((v == 2) && (h < 4));
                w = hit_in || hit_out || ((v == 3) && (h < 4));
                pix(h, v, p, w);
                chk("is_collision", {31'd0, is_collision}, {31'd0, coll_en && hit_in});
            end
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic [7:0] d,
                            input logic [7:0] sc, input logic [20:0] fc);
        chk({tag, " state"}, {29'd0, game_state}, {29'd0, st});
        chk({tag, " depth"}, {24'd0, wall_depth}, {24'd0, d});
        chk({tag, " score"}, {24'd0, score}, {24'd0, sc});
        chk({tag, " frame_collisions"}, {11'd0, frame_collisions}, {11'd0, fc});
    endtask

    initial begin
        //          start frames in out cen  st   depth  sc    fc
        vt[0]  = '{1'b1, 0,  0, 0, 1'b0, 3'd2, 8'd20, 8'd0, 21'd0};
        vt[1]  = '{1'b0, 1,  0, 0, 1'b0, 3'd2, 8'd20, 8'd0, 21'd0};
        vt[2]  = '{1'b0, 1,  0, 0, 1'b0, 3'd2, 8'd19, 8'd0, 21'd0};
        vt[3]  = '{1'b0, 13, 0, 0, 1'b0, 3'd2, 8'd13, 8'd0, 21'd0};
        vt[4]  = '{1'b0, 1,  0, 0, 1'b1, 3'd3, 8'd12, 8'd0, 21'd0};
        vt[5]  = '{1'b0, 9,  0, 0, 1'b1, 3'd3, 8'd8,  8'd0, 21'd0};
        vt[6]  = '{1'b0, 1,  0, 0, 1'b0, 3'd4, 8'd7,  8'd1, 21'd0};
        vt[7]  = '{1'b0, 2,  0, 0, 1'b0, 3'd4, 8'd7,  8'd1, 21'd0};
        vt[8]  = '{1'b0, 1,  0, 0, 1'b0, 3'd2, 8'd20, 8'd1, 21'd0};
        vt[9]  = '{1'b0, 2,  4, 0, 1'b0, 3'd2, 8'd19, 8'd1, 21'd0};
        vt[10] = '{1'b0, 14, 0, 0, 1'b0, 3'd3, 8'd12, 8'd1, 21'd0};
        vt[11] = '{1'b0, 1,  5, 0, 1'b1, 3'd3, 8'd12, 8'd1, 21'd0};
        vt[12] = '{1'b0, 1,  0, 4, 1'b1, 3'd3, 8'd11, 8'd1, 21'd5};
        vt[13] = '{1'b0, 1,  6, 0, 1'b1, 3'd3, 8'd11, 8'd1, 21'd0};
        vt[14] = '{1'b0, 1,  0, 0, 1'b0, 3'd0, 8'd11, 8'd1, 21'd6};
        vt[15] = '{1'b0, 3,  0, 0, 1'b0, 3'd0, 8'd11, 8'd1, 21'd0};

        rst = 1'b1;
        start = 1'b0;
        pix(19, 9, 1'b0, 1'b0);
        pix(19, 9, 1'b0, 1'b0);
        rst = 1'b0;
        chk_outs("reset", 3'd1, 8'd20, 8'd0, 21'd0);
        chk("reset is_collision", {31'd0, is_collision}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].start) begin
                idle(1'b1);
                idle(1'b0);
            end
            for (int f = 0; f < vt[i].frames; f++)
                run_frame(vt[i].ovl_in, vt[i].ovl_out, vt[i].coll_en);
            chk_outs($sformatf("vec%0d", i), vt[i].st, vt[i].depth, vt[i].sc, vt[i].fc);
        end

        // Holding start_in from GAME_OVER must cause exactly one move to IDLE.
        idle(1'b1);
        chk_outs("over->idle", 3'd1, 8'd20, 8'd1, 21'd0);
        repeat (99) idle(1'b1);
        chk_outs("start held", 3'd1, 8'd20, 8'd1, 21'd0);
        idle(1'b0);
        idle(1'b0);
        chk_outs("start released", 3'd1, 8'd20, 8'd1, 21'd0);

        // Second game: pass one wall, then reset in the middle of a CHECK frame.
        idle(1'b1);
        idle(1'b0);
        chk_outs("game2 start", 3'd2, 8'd20, 8'd0, 21'd0);
        repeat (29) run_frame(0, 0, 1'b0);
        chk_outs("game2 passed", 3'd2, 8'd20, 8'd1, 21'd0);
        repeat (16) run_frame(0, 0, 1'b0);
        chk_outs("game2 check", 3'd3, 8'd12, 8'd1, 21'd0);
        run_frame(2, 0, 1'b1);
        chk_outs("game2 two hits", 3'd3, 8'd12, 8'd1, 21'd0);

        pix(0, 0, 1'b0, 1'b0);
        for (int i = 1; i < 23; i++) begin
            logic hit;
            hit = (i / 20 == 1) && (i % 20 < 3);
            pix(i % 20, i / 20, hit, hit);
        end
        chk("pre-reset is_collision", {31'd0, is_collision}, 32'd1);
        chk("pre-reset frame_collisions", {11'd0, frame_collisions}, 32'd2);
        chk("pre-reset state", {29'd0, game_state}, 32'd3);

        rst = 1'b1;
        pix(3, 1, 1'b0, 1'b0);
        rst = 1'b0;
        chk_outs("mid reset", 3'd1, 8'd20, 8'd0, 21'd0);
        chk("mid reset is_collision", {31'd0, is_collision}, 32'd0);

        // The partial-frame count of 3 must not survive the reset.
        run_frame(0, 0, 1'b0);
        chk_outs("post reset frame", 3'd1, 8'd20, 8'd0, 21'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
